// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl
//   Miss handler behind the 2-way, 8-set data cache.
//   A load miss fetches the 4-word line over the mem_req/mem_ack word
//   interface, assembles it, and delivers it as a one-cycle fill.
//   A store miss performs one write-through word write and does not allocate.
//   The pipeline is stalled while either operation is in progress.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   miss_valid/we/addr/wdata missing access from the cache (sampled in IDLE only)
//   stall                    pipeline freeze
//   mem_req/we/addr/wdata    word request to memory (held until mem_ack)
//   mem_ack, mem_rdata       request accepted; read data is valid with the ack
//   fill_valid/set/tag/data  line fill to cache; word i at fill_data[32i+31:32i]
//   crit_valid, crit_data    critical-word strobe (critical-word-first build only)
//
// Configuration
//   DCACHE_REFILL_CRITICAL_WORD_FIRST_EN : when defined, the fetch starts at the
//   missing word and wraps, and crit_valid/crit_data report the first word one
//   cycle after its ack. When undefined, words arrive 0..3 and crit_* are 0.
module dcache_refill_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss_valid,
    input  logic         miss_we,
    input  logic [31:0]  miss_addr,
    input  logic [31:0]  miss_wdata,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
    output logic         fill_valid,
    output logic [2:0]   fill_set,
    output logic [24:0]  fill_tag,
    output logic [127:0] fill_data,
    output logic         crit_valid,
    output logic [31:0]  crit_data
);

    typedef enum logic [1:0] {IDLE, WRITE, FETCH, FILL} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;       // words received so far
    logic [1:0]      start_q, start_d;   // word index fetched first
    logic [3:0][31:0] line_q, line_d;    // line buffer, slot = word index
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            fill_valid_q, fill_valid_d;
    logic [2:0]      fill_set_q, fill_set_d;
    logic [24:0]     fill_tag_q, fill_tag_d;
    logic [1:0]      word, next_word;

    // Byte-in-word bits never matter to a word interface.
    logic unused_byte_bits;
    assign unused_byte_bits = ^miss_addr[1:0];

    // Current word index wraps naturally in 2 bits.
    assign word      = start_q + cnt_q;
    assign next_word = word + 2'd1;

`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
    logic        crit_valid_q, crit_valid_d;
    logic [31:0] crit_data_q, crit_data_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        line_d       = line_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        fill_valid_d = 1'b0;
        fill_set_d   = fill_set_q;
        fill_tag_d   = fill_tag_q;
`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    fill_tag_d = miss_addr[31:7];
                    fill_set_d = miss_addr[6:4];
                    cnt_d      = 2'd0;
                    mem_req_d  = 1'b1;
                    if (miss_we) begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {miss_addr[31:2], 2'b00};
                        mem_wdata_d = miss_wdata;
                    end else begin
                        state_d  = FETCH;
                        mem_we_d = 1'b0;
`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
                        start_d  = miss_addr[3:2];
`else
                        start_d  = 2'd0;
`endif
                        mem_addr_d = {miss_addr[31:4], start_d, 2'b00};
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    line_d[word] = mem_rdata;
                    cnt_d        = cnt_q + 2'd1;
`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
                    if (cnt_q == 2'd0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = mem_rdata;
                    end
`endif
                    if (cnt_q == 2'd3) begin
                        state_d      = FILL;
                        mem_req_d    = 1'b0;
                        fill_valid_d = 1'b1;
                    end else begin
                        // Next address goes out the cycle after the ack; req stays high.
                        mem_addr_d = {fill_tag_q, fill_set_q, next_word, 2'b00};
                    end
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            start_q      <= 2'd0;
            line_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_set_q   <= '0;
            fill_tag_q   <= '0;
`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            line_q       <= line_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            fill_valid_q <= fill_valid_d;
            fill_set_q   <= fill_set_d;
            fill_tag_q   <= fill_tag_d;
`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
`endif
        end
    end

    // Stall combinationally on a new miss so the missing access holds in place.
    assign stall      = (state_q == IDLE) ? miss_valid : 1'b1;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fill_valid = fill_valid_q;
    assign fill_set   = fill_set_q;
    assign fill_tag   = fill_tag_q;
    assign fill_data  = line_q;
`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl. Inputs change 1 time unit after
// the rising edge, outputs are sampled 2 units after it. A queue holds the
// expected memory requests (pushed when a miss is driven, popped on ack).
module tb_dcache_refill_ctrl;

    logic         clk, rst;
    logic         miss_valid, miss_we;
    logic [31:0]  miss_addr, miss_wdata;
    logic         stall, mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         fill_valid;
    logic [2:0]   fill_set;
    logic [24:0]  fill_tag;
    logic [127:0] fill_data;
    logic         crit_valid;
    logic [31:0]  crit_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] addr_q[$];   // expected read addresses, in order
    logic [64:0] wr_q[$];     // expected {we, addr, wdata} for stores

    dcache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_we(miss_we),
        .miss_addr(miss_addr), .miss_wdata(miss_wdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_tag(fill_tag),
        .fill_data(fill_data), .crit_valid(crit_valid), .crit_data(crit_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_valid = 1'b0; miss_we = 1'b0; miss_addr = '0;
        miss_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        rst = 1'b0; #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
        n_chk++; if ({mem_req, mem_we} !== 2'b00) $display("FAIL reset_req_we got %b want 00", {mem_req, mem_we}); else n_pass++;
        n_chk++; if ({mem_addr, mem_wdata} !== 64'd0) $display("FAIL reset_addr_wdata got %h want 0", {mem_addr, mem_wdata}); else n_pass++;
        n_chk++; if ({fill_valid, fill_set, fill_tag} !== 29'd0) $display("FAIL reset_fill_ctl got %h want 0", {fill_valid, fill_set, fill_tag}); else n_pass++;
        n_chk++; if (fill_data !== 128'd0) $display("FAIL reset_fill_data got %h want 0", fill_data); else n_pass++;
        n_chk++; if ({crit_valid, crit_data} !== 33'd0) $display("FAIL reset_crit got %h want 0", {crit_valid, crit_data}); else n_pass++;
        step();
    endtask

    // Load miss; memory returns the word's address as data. wt = ack-low cycles per word.
    task automatic run_load(input string nm, input logic [31:0] addr, input int wt, input bit toggle);
        logic [31:0]  base;
        logic [127:0] exp_line;
        int start, exp_fill, crit_cyc, waitc, cyc;
        base = {addr[31:4], 4'h0};
`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
        start = int'(addr[3:2]);
`else
        start = 0;
`endif
        addr_q.delete();
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(base + 32'(((start + i) % 4) * 4));
            exp_line[32*i +: 32] = base + 32'(4 * i);
        end
        exp_fill = 1 + 4 * (wt + 1);
        crit_cyc = 2 + wt;
        miss_valid = 1'b1; miss_we = 1'b0; miss_addr = addr; miss_wdata = $urandom; mem_ack = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL %s stall_c0 got %b want 1", nm, stall); else n_pass++;
        step();
        cyc = 1; waitc = 0;
        while (cyc <= exp_fill + 2) begin
            miss_valid = (toggle && cyc < exp_fill) ? 1'($urandom_range(0, 1)) : 1'b0;
            miss_addr  = toggle ? $urandom : addr;
            mem_ack    = mem_req && (waitc == wt);
            mem_rdata  = mem_ack ? mem_addr : $urandom;
            #1;
            n_chk++; if (stall !== (cyc <= exp_fill)) $display("FAIL %s stall_c%0d got %b want %b", nm, cyc, stall, cyc <= exp_fill); else n_pass++;
            n_chk++; if (fill_valid !== (cyc == exp_fill)) $display("FAIL %s fill_valid_c%0d got %b want %b", nm, cyc, fill_valid, cyc == exp_fill); else n_pass++;
            if (mem_req) begin
                n_chk++;
                if (addr_q.size() == 0) $display("FAIL %s extra_req_c%0d got addr %h want no request", nm, cyc, mem_addr);
                else if (mem_addr !== addr_q[0] || mem_we !== 1'b0) $display("FAIL %s req_c%0d got we=%b addr=%h want we=0 addr=%h", nm, cyc, mem_we, mem_addr, addr_q[0]);
                else n_pass++;
                if (mem_ack) begin
                    if (addr_q.size() > 0) void'(addr_q.pop_front());
                    waitc = 0;
                end else waitc++;
            end
            if (fill_valid) begin
                n_chk++;
                if ({fill_tag, fill_set, fill_data} !== {addr[31:7], addr[6:4], exp_line})
                    $display("FAIL %s fill got tag=%h set=%0d data=%h want tag=%h set=%0d data=%h", nm, fill_tag, fill_set, fill_data, addr[31:7], addr[6:4], exp_line);
                else n_pass++;
            end
`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
            n_chk++;
            if (crit_valid !== (cyc == crit_cyc) || (crit_valid && crit_data !== {addr[31:2], 2'b00}))
                $display("FAIL %s crit_c%0d got v=%b d=%h want v=%b d=%h", nm, cyc, crit_valid, crit_data, cyc == crit_cyc, {addr[31:2], 2'b00});
            else n_pass++;
`else
            n_chk++; if ({crit_valid, crit_data} !== 33'd0) $display("FAIL %s crit_c%0d got %h want 0", nm, cyc, {crit_valid, crit_data}); else n_pass++;
`endif
            step();
            cyc++;
        end
        mem_ack = 1'b0;
        n_chk++; if (addr_q.size() != 0) $display("FAIL %s words_left got %0d want 0", nm, addr_q.size()); else n_pass++;
    endtask

    task automatic test_load_basic();
        run_load("load_1238", 32'h0000_1238, 0, 1'b0);
    endtask

    task automatic test_load_wait();
        run_load("load_wait", 32'h0000_2A54, 2, 1'b0);
    endtask

    task automatic test_miss_toggle();
        run_load("toggle", 32'h0000_3000, 1, 1'b1);
    endtask

    task automatic test_store();
        int cyc, waitc;
        wr_q.delete();
        miss_valid = 1'b1; miss_we = 1'b1; miss_addr = 32'h0000_0044; miss_wdata = 32'hDEADBEEF;
        wr_q.push_back({1'b1, 32'h0000_0044, 32'hDEADBEEF});
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL store stall_c0 got %b want 1", stall); else n_pass++;
        step();
        cyc = 1; waitc = 0;
        while (cyc <= 6) begin
            miss_valid = 1'b0; miss_we = 1'b0; miss_wdata = $urandom;
            mem_ack = mem_req && (waitc == 3);
            mem_rdata = $urandom;
            #1;
            n_chk++; if (mem_req !== (cyc <= 4)) $display("FAIL store req_c%0d got %b want %b", cyc, mem_req, cyc <= 4); else n_pass++;
            if (mem_req) begin
                n_chk++;
                if (wr_q.size() == 0) $display("FAIL store extra_req_c%0d got %h want none", cyc, mem_addr);
                else if ({mem_we, mem_addr, mem_wdata} !== wr_q[0]) $display("FAIL store req_c%0d got %h want %h", cyc, {mem_we, mem_addr, mem_wdata}, wr_q[0]);
                else n_pass++;
                if (mem_ack) begin
                    if (wr_q.size() > 0) void'(wr_q.pop_front());
                end else waitc++;
            end
            n_chk++; if (stall !== (cyc <= 4)) $display("FAIL store stall_c%0d got %b want %b", cyc, stall, cyc <= 4); else n_pass++;
            n_chk++; if (fill_valid !== 1'b0) $display("FAIL store fill_c%0d got %b want 0", cyc, fill_valid); else n_pass++;
            step();
            cyc++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_rst_mid_fetch();
        miss_valid = 1'b1; miss_we = 1'b0; miss_addr = 32'h0000_1238;
        step();
        for (int c = 1; c <= 3; c++) begin
            miss_valid = 1'b0;
            mem_ack = mem_req; mem_rdata = mem_addr;
            if (c == 3) rst = 1'b1;
            step();
        end
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_fetch req got %b want 0", mem_req); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL rst_fetch stall got %b want 0", stall); else n_pass++;
        for (int c = 0; c < 6; c++) begin
            n_chk++; if (fill_valid !== 1'b0) $display("FAIL rst_fetch fill_c%0d got %b want 0", c, fill_valid); else n_pass++;
            step();
        end
        run_load("after_rst", 32'h0000_0080, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; miss_valid = 1'b0; miss_we = 1'b0; miss_addr = '0; miss_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_load_basic();
        test_store();
        test_load_wait();
        test_rst_mid_fetch();
        test_miss_toggle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_refill_ctrl.md
# dcache_refill_ctrl

Miss-handling stage directly downstream of the 2-way, 8-set data cache. On a load miss, fetches the 4-word (16-byte) line from main memory over a req/ack word interface, assembles it and hands it to the cache as a single fill. On a store miss, performs one write-through word write with no allocate. Holds the pipeline stalled for the duration of either operation.

## Interface
- Data_Width, 32, word width
- Addr_Width, 32, byte address width
- Tag_Width, 25, tag bits, addr[31:7]
- Set_Width, 3, set index bits, addr[6:4]
- BlockOffset, 2, word-in-line bits, addr[3:2]
- ByteOffset, 2, byte-in-word bits, addr[1:0], ignored

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- miss_valid  in  1  cache access missed this cycle (hit_out low on a valid access)
- miss_we  in  1  missing access is a store
- miss_addr  in  32  byte address of missing access
- miss_wdata  in  32  store data
- stall  out  1  freeze pipeline
- mem_req  out  1  memory request
- mem_we  out  1  request is a write
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  write data
- mem_ack  in  1  memory accepts the request; mem_rdata valid this cycle for reads
- mem_rdata  in  32  read data
- fill_valid  out  1  one-cycle line-fill strobe to cache
- fill_set  out  3  set to fill
- fill_tag  out  25  tag to install
- fill_data  out  128  line; word i at [32i+31:32i]
- crit_valid  out  1  critical word available (macro only)
- crit_data  out  32  critical word (macro only)

## Operation
- States: IDLE, WRITE, FETCH, FILL.
- IDLE: on miss_valid, latch miss_addr/miss_wdata/miss_we; miss_we=1 -> WRITE, else -> FETCH. Word counter cleared.
- WRITE: mem_req=1, mem_we=1, mem_addr={miss_addr[31:2],2'b00}, mem_wdata=latched data. On mem_ack -> IDLE. No fill.
- FETCH: mem_req=1, mem_we=0, mem_addr={tag,set,word,2'b00}. On mem_ack: store mem_rdata in line buffer slot `word`, increment 2-bit counter. Ack on the 4th word -> FILL.
- FILL: fill_valid=1 for exactly one cycle with latched set/tag and full buffer -> IDLE.
- Default word order 0,1,2,3 from line base (addr[3:0]=0).
- mem_addr/mem_we/mem_wdata stable while mem_req high and mem_ack low. Next word's address presented the cycle after ack; mem_req stays high across words.
- stall = miss_valid in IDLE (combinational) OR state != IDLE. Cache writes the line on the FILL edge; access replays and hits in the first IDLE cycle.
- miss_valid ignored outside IDLE.
- Line buffer not cleared between misses; only fully fetched lines are ever strobed.

## Timing
- Reset values: stall=0 (with miss_valid=0), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill_valid=0, fill_set=0, fill_tag=0, fill_data=0, crit_valid=0, crit_data=0; state IDLE, counter 0.
- Load miss at cycle 0, mem_ack high every request cycle: FETCH cycles 1-4, FILL cycle 5, stall low cycle 6. Each ack-wait cycle adds 1.
- Store miss, ack in first cycle: WRITE cycle 1, IDLE cycle 2.
- rst mid-FETCH/WRITE: IDLE next edge, mem_req low, partial line discarded, no fill_valid; memory must drop an unacked request.
- rst during FILL wins: fill_valid low after that edge, no further fill.

## Configuration
- DCACHE_REFILL_CRITICAL_WORD_FIRST_EN defined: fetch starts at word w=miss_addr[3:2], order w, w+1, w+2, w+3 mod 4 (wraps past 3 to 0); crit_valid pulses one cycle, registered, the cycle after the first word's ack, crit_data=that word. Fill contents and stall timing unchanged.
- Not defined: order always 0..3; crit_valid and crit_data tied 0.

## Test plan
- Load miss addr 0x0000_1238, ack every cycle, memory word = address -> mem_addr 0x1230,0x1234,0x1238,0x123C; fill_valid in cycle 5, set=3, tag=0x24, fill_data={0x123C,0x1238,0x1234,0x1230}; stall low cycle 6.
- Store miss addr 0x0000_0044, data 0xDEADBEEF, ack delayed 3 cycles -> mem_we=1, mem_addr 0x44, mem_wdata stable 4 cycles, no fill_valid, stall low the cycle after ack.
- Load miss with ack low 2 cycles before each word -> address stable while unacked, FILL after 12 FETCH cycles, line correct.
- rst asserted in 3rd FETCH cycle -> mem_req 0 next cycle, no fill_valid; subsequent miss 0x80 fills set 0 correctly.
- With macro, load miss 0x0000_1238 -> mem_addr 0x1238,0x123C,0x1230,0x1234; crit_valid one cycle, crit_data=0x1238; fill_data identical to scenario 1.
- miss_valid toggled during FETCH -> ignored, single fill only.
